// File: rtl/evo_bsp_pkg.sv
// Shared EVO board-support definitions: register offsets, decode selector
// and byte-lane sizing helper used by the pin port and related blocks.
package evo_bsp_pkg;

    // Register block offsets, each scaled by the number of byte lanes
    localparam int DDR_OFS   = 0;
    localparam int PORT_OFS  = 1;
    localparam int PIN_OFS   = 2;
    localparam int PCMSK_OFS = 3;
    localparam int PCIF_OFS  = 4;
    localparam int NUM_REGS  = 5;

    typedef enum logic [2:0] {
        REG_DDR   = 3'd0,
        REG_PORT  = 3'd1,
        REG_PIN   = 3'd2,
        REG_PCMSK = 3'd3,
        REG_PCIF  = 3'd4,
        REG_NONE  = 3'd7
    } reg_sel_e;

    // Number of 8-bit lanes needed to cover a port of the given width
    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/evo_sync_edge.sv
// Multi-stage input synchroniser with a trailing "previous" flop; reports
// the synchronised level and a per-bit change strobe.
module evo_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] chg
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Shift raw pad levels through the synchroniser chain, then into prev
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= {WIDTH{1'b0}};
            end
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign sync = r_stage[SYNC_STAGES-1];
    assign chg  = r_stage[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/evo_pin_port.sv
// Register-mapped pin port: per-bit direction, output, synchronised input,
// pin-change flags with mask-gated interrupt, and a stretched activity LED.
module evo_pin_port
    import evo_bsp_pkg::*;
#(
    parameter int         WIDTH          = 32,
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         SYNC_STAGES    = 2,
    parameter int         LED_BIT        = 0,
    parameter int         STRETCH_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ramadr,
    input  logic             ramre,
    input  logic             ramwe,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       io_out,
    output logic             io_out_en,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq,
    output logic             led
);

    localparam int             NB      = nbytes(WIDTH);
    localparam int             LW      = NB * 8;
    // Bits at or above WIDTH are held at zero by masking every update
    localparam logic [LW-1:0]  VMASK   = LW'({WIDTH{1'b1}});
    localparam logic [15:0]    STRETCH = 16'(STRETCH_CYCLES);

    logic [LW-1:0] r_ddr;
    logic [LW-1:0] r_port;
    logic [LW-1:0] r_pcmsk;
    logic [LW-1:0] r_pcif;
    logic [15:0]   r_cnt;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_chg;
    logic [LW-1:0]    w_sync_x;
    logic [LW-1:0]    w_chg_x;
    logic [7:0]       w_ofs;
    logic [7:0]       w_reg;
    logic [7:0]       w_lane;
    reg_sel_e         w_sel;
    logic [LW-1:0]    w_bmask;
    logic [LW-1:0]    w_wdata;
    logic [LW-1:0]    w_clr;
    logic [LW-1:0]    w_rd_vec;
    logic             w_led_rise;

    evo_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pad_in),
        .sync    (w_sync),
        .chg     (w_chg)
    );

    assign w_sync_x = LW'(w_sync);
    assign w_chg_x  = LW'(w_chg);

    // Window-relative offset splits into register block and byte lane
    assign w_ofs   = ramadr - BASE_ADDR;
    assign w_reg   = w_ofs / 8'(NB);
    assign w_lane  = w_ofs % 8'(NB);
    assign w_bmask = (LW'(8'hFF) << {w_lane, 3'b000}) & VMASK;
    assign w_wdata = {NB{dbus_in}};

    // Decode the addressed register; anything outside the window is REG_NONE
    always_comb begin
        w_sel = REG_NONE;
        if (w_ofs < 8'(NUM_REGS * NB)) begin
            case (w_reg)
                8'(DDR_OFS):   w_sel = REG_DDR;
                8'(PORT_OFS):  w_sel = REG_PORT;
                8'(PIN_OFS):   w_sel = REG_PIN;
                8'(PCMSK_OFS): w_sel = REG_PCMSK;
                8'(PCIF_OFS):  w_sel = REG_PCIF;
                default:       w_sel = REG_NONE;
            endcase
        end else begin
            w_sel = REG_NONE;
        end
    end

    // Write-1-to-clear mask for the change flags
    always_comb begin
        if (ramwe && (w_sel == REG_PCIF)) begin
            w_clr = w_wdata & w_bmask;
        end else begin
            w_clr = {LW{1'b0}};
        end
    end

    // Direction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ddr <= {LW{1'b0}};
        end else if (ramwe && (w_sel == REG_DDR)) begin
            r_ddr <= (r_ddr & ~w_bmask) | (w_wdata & w_bmask);
        end
    end

    // Output register: direct write via PORT, toggle via writes to PIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port <= {LW{1'b0}};
        end else if (ramwe && (w_sel == REG_PORT)) begin
            r_port <= (r_port & ~w_bmask) | (w_wdata & w_bmask);
        end else if (ramwe && (w_sel == REG_PIN)) begin
            r_port <= r_port ^ (w_wdata & w_bmask);
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcmsk <= {LW{1'b0}};
        end else if (ramwe && (w_sel == REG_PCMSK)) begin
            r_pcmsk <= (r_pcmsk & ~w_bmask) | (w_wdata & w_bmask);
        end
    end

    // Change flags: a new change in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcif <= {LW{1'b0}};
        end else begin
            r_pcif <= ((r_pcif & ~w_clr) | w_chg_x) & VMASK;
        end
    end

    assign w_led_rise = w_sync[LED_BIT] & w_chg[LED_BIT];

    // LED stretch counter: reload on each rising edge, otherwise run down to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'h0000;
        end else if (w_led_rise) begin
            r_cnt <= STRETCH;
        end else if (r_cnt != 16'h0000) begin
            r_cnt <= r_cnt - 16'h0001;
        end
    end

    // Read-data source for the addressed register block
    always_comb begin
        case (w_sel)
            REG_DDR:   w_rd_vec = r_ddr;
            REG_PORT:  w_rd_vec = r_port;
            REG_PIN:   w_rd_vec = w_sync_x;
            REG_PCMSK: w_rd_vec = r_pcmsk;
            REG_PCIF:  w_rd_vec = r_pcif;
            default:   w_rd_vec = {LW{1'b0}};
        endcase
    end

    // Combinational read port; returns zero unless a read hits the window
    always_comb begin
        if (ramre && (w_sel != REG_NONE)) begin
            io_out    = 8'(w_rd_vec >> {w_lane, 3'b000});
            io_out_en = 1'b1;
        end else begin
            io_out    = 8'h00;
            io_out_en = 1'b0;
        end
    end

    assign pad_out = r_port[WIDTH-1:0];
    assign pad_oe  = r_ddr[WIDTH-1:0];
    assign irq     = |(r_pcif & r_pcmsk);
    assign led     = w_sync[LED_BIT] | (r_cnt != 16'h0000);

endmodule

// File: tb/tb_evo_pin_port.sv
// Self-checking bench for evo_pin_port: a 32-pad instance at 8'h00 and a
// 12-pad instance at 8'h40 sharing one register bus.
module tb_evo_pin_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ramadr;
    logic        ramre;
    logic        ramwe;
    logic [7:0]  dbus_in;
    logic [7:0]  io_out;
    logic        io_out_en;
    logic [31:0] pad_in;
    logic [31:0] pad_out;
    logic [31:0] pad_oe;
    logic        irq;
    logic        led;
    logic [7:0]  io_out2;
    logic        io_out_en2;
    logic [11:0] pad_in2;
    logic [11:0] pad_out2;
    logic [11:0] pad_oe2;
    logic        irq2;
    logic        led2;

    always #10 clk = ~clk;

    evo_pin_port #(
        .WIDTH(32), .BASE_ADDR(8'h00), .SYNC_STAGES(2), .LED_BIT(0), .STRETCH_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst(rst), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dbus_in(dbus_in), .io_out(io_out), .io_out_en(io_out_en),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq), .led(led)
    );

    evo_pin_port #(
        .WIDTH(12), .BASE_ADDR(8'h40), .SYNC_STAGES(2), .LED_BIT(0), .STRETCH_CYCLES(16)
    ) u_dut12 (
        .clk(clk), .rst(rst), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dbus_in(dbus_in), .io_out(io_out2), .io_out_en(io_out_en2),
        .pad_in(pad_in2), .pad_out(pad_out2), .pad_oe(pad_oe2), .irq(irq2), .led(led2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0]  waddr;
        logic [7:0]  wdata;
        logic [7:0]  raddr;
        logic [7:0]  exp_rd;
        logic [31:0] exp_oe;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vt[8];

    task automatic sb_push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] act);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow actual=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        sb_push(n, expv);
        sb_check(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ramadr  = a;
        dbus_in = d;
        ramwe   = 1'b1;
        tick();
        ramwe   = 1'b0;
    endtask

    // Returns {en2, io_out2, en, io_out}
    task automatic rd(input logic [7:0] a, output logic [17:0] r);
        ramadr = a;
        ramre  = 1'b1;
        #1;
        r = {io_out_en2, io_out2, io_out_en, io_out};
        ramre  = 1'b0;
    endtask

    initial begin
        logic [17:0] r;
        logic        e;

        vt[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 32'h000000A5, 32'h00000000};
        vt[1] = '{8'h04, 8'h0F, 8'h04, 8'h0F, 32'h000000A5, 32'h0000000F};
        vt[2] = '{8'h08, 8'hFF, 8'h04, 8'hF0, 32'h000000A5, 32'h000000F0};
        vt[3] = '{8'h03, 8'hC3, 8'h03, 8'hC3, 32'hC30000A5, 32'h000000F0};
        vt[4] = '{8'h07, 8'h81, 8'h07, 8'h81, 32'hC30000A5, 32'h810000F0};
        vt[5] = '{8'h0B, 8'h01, 8'h07, 8'h80, 32'hC30000A5, 32'h800000F0};
        vt[6] = '{8'h0D, 8'h01, 8'h0D, 8'h01, 32'hC30000A5, 32'h800000F0};
        vt[7] = '{8'h14, 8'hFF, 8'h00, 8'hA5, 32'hC30000A5, 32'h800000F0};

        rst = 1'b1; ramadr = 8'h00; ramre = 1'b0; ramwe = 1'b0; dbus_in = 8'h00;
        pad_in = 32'hFFFFFFFF; pad_in2 = 12'hFFF;

        // Reset state
        repeat (3) tick();
        chk("rst_pad_oe", pad_oe, 32'h0);
        chk("rst_pad_out", pad_out, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_led", {31'h0, led}, 32'h0);
        chk("rst_io_out", {24'h0, io_out}, 32'h0);
        chk("rst_io_out_en", {31'h0, io_out_en}, 32'h0);
        chk("rst_pad_oe12", {20'h0, pad_oe2}, 32'h0);

        // Pads idling high flag a change on the third edge after release
        rst = 1'b0;
        tick(); tick();
        rd(8'h10, r); chk("pcif_edge2", {24'h0, r[7:0]}, 32'h00);
        tick();
        for (int k = 0; k < 4; k++) begin
            rd(8'(8'h10 + k), r);
            chk("pcif_after_rst", {24'h0, r[7:0]}, 32'hFF);
        end
        rd(8'h48, r); chk("pcif12_lane0", {24'h0, r[16:9]}, 32'hFF);
        rd(8'h49, r); chk("pcif12_lane1", {24'h0, r[16:9]}, 32'h0F);

        // Table-driven register write / readback
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].waddr, vt[i].wdata);
            sb_push($sformatf("vec%0d_pad_oe", i), vt[i].exp_oe);
            sb_push($sformatf("vec%0d_pad_out", i), vt[i].exp_out);
            sb_push($sformatf("vec%0d_rd", i), {24'h0, vt[i].exp_rd});
            sb_check(pad_oe);
            sb_check(pad_out);
            rd(vt[i].raddr, r);
            sb_check({24'h0, r[7:0]});
        end

        // Miss / strobe-off reads
        rd(8'h14, r); chk("miss_en", {31'h0, r[8]}, 32'h0);
        chk("miss_data", {24'h0, r[7:0]}, 32'h0);
        ramadr = 8'h00; #1; chk("no_re_en", {31'h0, io_out_en}, 32'h0);

        // Same-cycle read and write return the old value
        ramadr = 8'h00; dbus_in = 8'h5A; ramwe = 1'b1; ramre = 1'b1; #1;
        chk("rw_old", {24'h0, io_out}, 32'hA5);
        tick(); ramwe = 1'b0; ramre = 1'b0;
        rd(8'h00, r); chk("rw_new", {24'h0, r[7:0]}, 32'h5A);

        // PIN reflects pads after two edges
        pad_in = 32'h12345678;
        tick();
        rd(8'h08, r); chk("pin_edge1", {24'h0, r[7:0]}, 32'hFF);
        tick();
        rd(8'h08, r); chk("pin_l0", {24'h0, r[7:0]}, 32'h78);
        rd(8'h09, r); chk("pin_l1", {24'h0, r[7:0]}, 32'h56);
        rd(8'h0A, r); chk("pin_l2", {24'h0, r[7:0]}, 32'h34);
        rd(8'h0B, r); chk("pin_l3", {24'h0, r[7:0]}, 32'h12);
        repeat (3) tick();
        for (int k = 0; k < 4; k++) wr(8'(8'h10 + k), 8'hFF);
        chk("irq_idle", {31'h0, irq}, 32'h0);

        // Masked change on pad 8: irq exactly three edges later
        pad_in[8] = ~pad_in[8];
        tick(); tick();
        chk("irq_edge2", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_edge3", {31'h0, irq}, 32'h1);
        wr(8'h11, 8'h01);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Unmasked change on pad 9 sets the flag only
        pad_in[9] = ~pad_in[9];
        repeat (4) tick();
        chk("irq_unmasked", {31'h0, irq}, 32'h0);
        rd(8'h11, r); chk("pcif_bit9", {24'h0, r[7:0]}, 32'h02);
        wr(8'h11, 8'h02);

        // Set and clear on the same edge: set wins
        pad_in[8] = ~pad_in[8];
        tick(); tick();
        wr(8'h11, 8'h01);
        rd(8'h11, r); chk("collide_pcif", {24'h0, r[7:0]}, 32'h01);
        chk("collide_irq", {31'h0, irq}, 32'h1);
        wr(8'h11, 8'h01);
        rd(8'h11, r); chk("clear_after", {24'h0, r[7:0]}, 32'h00);

        // Single pulse: led high 17 cycles starting at the second edge
        chk("led_idle", {31'h0, led}, 32'h0);
        pad_in[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) pad_in[0] = 1'b0;
            e = (k >= 2) && (k <= 18);
            chk($sformatf("led1_k%0d", k), {31'h0, led}, {31'h0, e});
        end

        // Second pulse mid-stretch reloads the counter
        pad_in[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) pad_in[0] = 1'b0;
            if (k == 8) pad_in[0] = 1'b1;
            if (k == 9) pad_in[0] = 1'b0;
            e = (k >= 2) && (k <= 26);
            chk($sformatf("led2_k%0d", k), {31'h0, led}, {31'h0, e});
        end

        // WIDTH=12 instance: upper lane and window boundary
        wr(8'h41, 8'hFF);
        chk("w12_pad_oe", {20'h0, pad_oe2}, 32'h00000F00);
        rd(8'h41, r); chk("w12_ddr_rd", {24'h0, r[16:9]}, 32'h0F);
        rd(8'h49, r); chk("w12_last_en", {31'h0, r[17]}, 32'h1);
        rd(8'h4A, r); chk("w12_past_en", {31'h0, r[17]}, 32'h0);
        rd(8'h3F, r); chk("w12_below_en", {31'h0, r[17]}, 32'h0);

        // Reset during a stretch with a pending interrupt
        wr(8'h10, 8'hFF);
        wr(8'h0C, 8'h01);
        pad_in[0] = 1'b1;
        tick();
        pad_in[0] = 1'b0;
        repeat (4) tick();
        chk("pre_rst_led", {31'h0, led}, 32'h1);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_led", {31'h0, led}, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        chk("async_rst_oe", pad_oe, 32'h0);
        chk("async_rst_out", pad_out, 32'h0);
        chk("async_rst_oe12", {20'h0, pad_oe2}, 32'h0);
        tick();
        rst = 1'b0;
        rd(8'h10, r); chk("post_rst_pcif", {24'h0, r[7:0]}, 32'h00);
        rd(8'h0C, r); chk("post_rst_pcmsk", {24'h0, r[7:0]}, 32'h00);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
